// File: rtl/bram_stream_reader_if.sv
// Purpose : command, BRAM read-port and output-stream bundle for bram_stream_reader.
// Ports   : master = the reader (drives rd_addr, stream outputs, busy/done),
//           slave  = the environment (drives start/base/length, rd_data, out_ready).
interface bram_stream_reader_if #(
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int WEIGHT_WIDTH    = 8
) ();

  // command side
  logic                       start;
  logic [BRAM_ADDR_WIDTH-1:0] base_addr;
  logic [BRAM_ADDR_WIDTH:0]   length;
  logic                       busy;
  logic                       done;

  // asynchronous-read BRAM port
  logic [BRAM_ADDR_WIDTH-1:0] rd_addr;
  logic [WEIGHT_WIDTH-1:0]    rd_data;

  // valid/ready output stream towards the MAC array
  logic [WEIGHT_WIDTH-1:0]    out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_row_end;
  logic                       out_last;

  modport master (
    input  start, base_addr, length, rd_data, out_ready,
    output busy, done, rd_addr, out_data, out_valid, out_row_end, out_last
  );

  modport slave (
    output start, base_addr, length, rd_data, out_ready,
    input  busy, done, rd_addr, out_data, out_valid, out_row_end, out_last
  );

endinterface

// File: rtl/bram_stream_reader.sv
// Purpose : walks a contiguous BRAM address range (wrapping at BRAM_DEPTH) and turns the
//           combinational read data into a registered valid/ready stream with row/last marks.
// Latency : start sampled at edge N -> first out_valid after edge N+1; one beat per cycle
//           while out_ready stays high; done pulses one cycle after the last beat is accepted.
// Backpressure: out_valid && !out_ready freezes out_data/out_last/out_row_end and rd_addr.
// Ports   : clk, rst (async, active-high) plus bus (bram_stream_reader_if.master):
//           start/base_addr/length command, busy/done status, rd_addr/rd_data BRAM port,
//           out_data/out_valid/out_ready/out_row_end/out_last stream.
module bram_stream_reader #(
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int WEIGHT_WIDTH    = 8,
  parameter int BRAM_DEPTH      = 784,
  parameter int ROW_LEN         = 28
) (
  input  logic                   clk,
  input  logic                   rst,
  bram_stream_reader_if.master   bus
);

  localparam int AW    = BRAM_ADDR_WIDTH;
  localparam int LW    = BRAM_ADDR_WIDTH + 1;
  localparam int COL_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

  localparam logic [LW-1:0]    DEPTH_L  = LW'(BRAM_DEPTH);
  localparam logic [AW-1:0]    ADDR_MAX = AW'(BRAM_DEPTH - 1);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(ROW_LEN - 1);
  localparam logic [LW-1:0]    ONE_L    = LW'(1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                  state;
  logic [LW-1:0]           remaining;
  logic [COL_W-1:0]        col;
  logic [AW-1:0]           rd_addr_q;
  logic [WEIGHT_WIDTH-1:0] out_data_q;
  logic                    out_valid_q;
  logic                    out_row_end_q;
  logic                    out_last_q;
  logic                    busy_q;
  logic                    done_q;

  // Command sanitising: an over-long transfer is clamped to the whole memory and an
  // out-of-range base restarts at address 0 rather than walking non-existent words.
  logic [LW-1:0] eff_len;
  logic [AW-1:0] eff_base;

  always_comb begin
    eff_len  = (bus.length > DEPTH_L) ? DEPTH_L : bus.length;
    eff_base = ({1'b0, bus.base_addr} < DEPTH_L) ? bus.base_addr : '0;
  end

  // Output register pipeline control.
  //   accept : the beat currently held in the output register is taken this edge.
  //   load   : a new word is captured, either into an empty register or replacing
  //            the beat being accepted (gives one beat per cycle under ready=1).
  //   finish : the accepted beat is the final one of the transfer.
  logic accept;
  logic load;
  logic finish;
  logic last_word;
  logic row_wrap;
  logic addr_wrap;

  always_comb begin
    accept    = out_valid_q && bus.out_ready;
    load      = (state == STREAM) && (remaining != '0) && (!out_valid_q || bus.out_ready);
    finish    = (state == STREAM) && accept && out_last_q;
    last_word = (remaining == ONE_L);
    row_wrap  = (col == COL_MAX);
    addr_wrap = (rd_addr_q == ADDR_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      remaining     <= '0;
      col           <= '0;
      rd_addr_q     <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_row_end_q <= 1'b0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      // done is a single-cycle pulse; every path below that wants it sets it again.
      done_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            if (eff_len == '0) begin
              // Nothing to stream: report completion straight away, never go busy.
              done_q <= 1'b1;
            end else begin
              rd_addr_q <= eff_base;
              remaining <= eff_len;
              col       <= '0;
              busy_q    <= 1'b1;
              state     <= STREAM;
            end
          end
        end

        STREAM: begin
          if (load) begin
            // rd_data is combinational from rd_addr_q, so it already reflects the
            // word for this beat; the address then advances to prefetch the next.
            out_data_q    <= bus.rd_data;
            out_valid_q   <= 1'b1;
            out_last_q    <= last_word;
            out_row_end_q <= row_wrap || last_word;
            remaining     <= remaining - ONE_L;
            col           <= row_wrap ? '0 : col + 1'b1;
            rd_addr_q     <= addr_wrap ? '0 : rd_addr_q + 1'b1;
          end else if (accept) begin
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_row_end_q <= 1'b0;
          end

          // The final beat can only be in the register once remaining is 0, so
          // finish never coincides with load.
          if (finish) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd_addr     = rd_addr_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_row_end = out_row_end_q;
  assign bus.out_last    = out_last_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

  // Completion is reported only after the final beat has left the register.
  a_done_not_with_valid: assert property (@(posedge clk) disable iff (rst)
    !(done_q && out_valid_q));

  // A stalled beat must be presented unchanged on the next cycle.
  a_stall_holds: assert property (@(posedge clk) disable iff (rst)
    (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_data_q) &&
                                         $stable(out_last_q) && $stable(out_row_end_q)));

  // The read address never leaves the populated memory range.
  a_addr_in_range: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, rd_addr_q} < DEPTH_L));

endmodule

// File: tb/tb_bram_stream_reader.sv
`timescale 1ns/1ps
module tb_bram_stream_reader;

  localparam int AW    = 10;
  localparam int WW    = 8;
  localparam int DEPTH = 784;
  localparam int ROW   = 28;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_stream_reader_if #(.BRAM_ADDR_WIDTH(AW), .WEIGHT_WIDTH(WW)) bif ();

  bram_stream_reader #(
    .BRAM_ADDR_WIDTH(AW), .WEIGHT_WIDTH(WW), .BRAM_DEPTH(DEPTH), .ROW_LEN(ROW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  // Asynchronous-read BRAM model.
  logic [WW-1:0] mem [DEPTH];
  assign bif.rd_data = (int'(bif.rd_addr) < DEPTH) ? mem[bif.rd_addr] : '0;

  typedef struct packed {
    logic [WW-1:0] data;
    logic          row_end;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  beat_t log_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: which transfer is in flight and what completion looks like.
  bit    active       = 1'b0;
  bit    done_due     = 1'b0;
  int    since_start  = -1;
  int    exp_end_addr = -1;
  int    busy_cycles  = 0;
  int    done_count   = 0;
  bit    stall_prev   = 1'b0;
  beat_t stall_beat;
  int    stall_addr   = 0;

  int ready_mode = 0;
  int pat_i      = 0;
  logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream ready generator, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bif.out_ready = 1'b1;
      1: begin
        bif.out_ready = pat[pat_i];
        pat_i = (pat_i + 1) % 7;
      end
      default: bif.out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Compare process: outputs are sampled on the falling edge; the inputs seen here
  // are the ones the next rising edge will sample, so the model advances here too.
  always @(negedge clk) begin : cmp
    beat_t cur;
    beat_t e;
    beat_t b;
    bit    was_active;
    int    el;
    int    eb;
    if (rst) begin
      exp_q.delete();
      active       = 1'b0;
      done_due     = 1'b0;
      since_start  = -1;
      stall_prev   = 1'b0;
      exp_end_addr = -1;
    end else begin
      was_active = active;
      cur = '{data: bif.out_data, row_end: bif.out_row_end, last: bif.out_last};

      check("done", bif.done, done_due);
      check("busy", bif.busy, active);
      if (bif.busy) busy_cycles++;
      if (bif.done) begin
        done_count++;
        check("done_with_valid", bif.out_valid, 0);
        if (exp_end_addr >= 0) check("end_rd_addr", bif.rd_addr, exp_end_addr);
      end
      if (!active) check("idle_valid", bif.out_valid, 0);

      if (since_start >= 0) begin
        since_start++;
        if (since_start == 2) begin
          check("first_beat_latency", bif.out_valid, 1);
          since_start = -1;
        end
      end

      if (stall_prev) begin
        check("stall_valid", bif.out_valid, 1);
        check("stall_beat", cur, stall_beat);
        check("stall_rd_addr", bif.rd_addr, stall_addr);
      end
      stall_prev = bif.out_valid && !bif.out_ready;
      stall_beat = cur;
      stall_addr = int'(bif.rd_addr);

      done_due = 1'b0;
      if (bif.out_valid && bif.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", cur.data, e.data);
          check("beat_row_end", cur.row_end, e.row_end);
          check("beat_last", cur.last, e.last);
          log_q.push_back(cur);
          if (e.last) begin
            done_due = 1'b1;
            active   = 1'b0;
          end
        end
      end

      if (bif.start && !was_active) begin
        el = (int'(bif.length) > DEPTH) ? DEPTH : int'(bif.length);
        eb = (int'(bif.base_addr) < DEPTH) ? int'(bif.base_addr) : 0;
        if (el == 0) begin
          done_due     = 1'b1;
          exp_end_addr = -1;
        end else begin
          active       = 1'b1;
          since_start  = 0;
          exp_end_addr = (eb + el) % DEPTH;
          for (int k = 0; k < el; k++) begin
            b.data    = mem[(eb + k) % DEPTH];
            b.last    = (k == el - 1);
            b.row_end = (((k + 1) % ROW) == 0) || b.last;
            exp_q.push_back(b);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int base, input int len);
    @(posedge clk); #1;
    bif.start     = 1'b1;
    bif.base_addr = AW'(base);
    bif.length    = (AW+1)'(len);
    @(posedge clk); #1;
    bif.start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit got;
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk); #1;
      if (bif.done) got = 1'b1;
    end
    if (!got) check(name, 0, 1);
    tick(2);
  endtask

  task automatic count_marks(output int n_row, output int n_last);
    n_row  = 0;
    n_last = 0;
    foreach (log_q[i]) begin
      if (log_q[i].row_end) n_row++;
      if (log_q[i].last)    n_last++;
    end
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    int nr;
    int nl;
    int wrap_exp [8];
    bit got3;

    rst = 1'b1;
    bif.start = 1'b0;
    bif.base_addr = '0;
    bif.length = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = WW'(i % 256);

    tick(3);
    check("rst_out_valid", bif.out_valid, 0);
    check("rst_busy", bif.busy, 0);
    check("rst_done", bif.done, 0);
    check("rst_rd_addr", bif.rd_addr, 0);
    check("rst_out_data", bif.out_data, 0);
    check("rst_out_last", bif.out_last, 0);
    check("rst_out_row_end", bif.out_row_end, 0);
    rst = 1'b0;
    tick(2);

    // Full image, ready held high.
    ready_mode = 0; log_q.delete(); busy_cycles = 0; done_count = 0;
    issue(0, 784);
    wait_done(2000, "full_timeout");
    count_marks(nr, nl);
    check("full_beats", log_q.size(), 784);
    check("full_busy_cycles", busy_cycles, 785);
    check("full_done_count", done_count, 1);
    check("full_row_ends", nr, 28);
    check("full_lasts", nl, 1);
    if (log_q.size() == 784) begin
      check("full_b26_row_end", log_q[26].row_end, 0);
      check("full_b27_row_end", log_q[27].row_end, 1);
      check("full_b255_data", log_q[255].data, 255);
      check("full_b256_data", log_q[256].data, 0);
      check("full_b783_data", log_q[783].data, 15);
      check("full_b783_last", log_q[783].last, 1);
    end

    // Backpressure with the fixed ready pattern.
    ready_mode = 1; pat_i = 0; log_q.delete();
    issue(10, 5);
    wait_done(200, "bp_timeout");
    check("bp_beats", log_q.size(), 5);
    if (log_q.size() == 5) begin
      for (int i = 0; i < 5; i++) check("bp_data", log_q[i].data, 10 + i);
      check("bp_last3", log_q[3].last, 0);
      check("bp_last4", log_q[4].last, 1);
    end

    // Address wrap 780..783, 0..3.
    ready_mode = 0; log_q.delete();
    wrap_exp = '{12, 13, 14, 15, 0, 1, 2, 3};
    issue(780, 8);
    wait_done(200, "wrap_timeout");
    count_marks(nr, nl);
    check("wrap_beats", log_q.size(), 8);
    check("wrap_row_ends", nr, 1);
    if (log_q.size() == 8) begin
      for (int i = 0; i < 8; i++) check("wrap_data", log_q[i].data, wrap_exp[i]);
      check("wrap_b7_row_end", log_q[7].row_end, 1);
    end

    // Zero length and clamp.
    log_q.delete();
    issue(0, 0);
    check("zero_done", bif.done, 1);
    check("zero_busy", bif.busy, 0);
    tick(1);
    check("zero_done_drop", bif.done, 0);
    check("zero_beats", log_q.size(), 0);
    ready_mode = 2;
    issue(0, 1000);
    wait_done(4000, "clamp_timeout");
    check("clamp_beats", log_q.size(), 784);

    // Start while busy is ignored.
    log_q.delete();
    issue(100, 30);
    tick(5);
    issue(0, 3);
    wait_done(400, "busy_start_timeout");
    check("busy_start_beats", log_q.size(), 30);
    if (log_q.size() == 30) begin
      check("busy_start_first", log_q[0].data, 100);
      check("busy_start_final", log_q[29].data, 129);
    end

    // Asynchronous reset in the middle of a transfer.
    ready_mode = 0; log_q.delete();
    issue(200, 20);
    got3 = 1'b0;
    for (int c = 0; c < 50 && !got3; c++) begin
      @(negedge clk);
      if (log_q.size() >= 3) got3 = 1'b1;
    end
    if (!got3) check("midrst_reach_beat3", 0, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", bif.out_valid, 0);
    check("midrst_busy", bif.busy, 0);
    check("midrst_rd_addr", bif.rd_addr, 0);
    check("midrst_done", bif.done, 0);
    tick(2);
    rst = 1'b0;
    tick(3);
    log_q.delete();
    issue(5, 2);
    wait_done(50, "after_rst_timeout");
    check("after_rst_beats", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("after_rst_d0", log_q[0].data, 5);
      check("after_rst_d1", log_q[1].data, 6);
    end

    // Randomised transfers over random memory contents.
    for (int it = 0; it < 14; it++) begin
      int b;
      int l;
      for (int i = 0; i < DEPTH; i++) mem[i] = WW'($urandom);
      b = $urandom_range(0, 1023);
      l = (it % 5 == 4) ? $urandom_range(700, 1023) : $urandom_range(0, 70);
      ready_mode = (it % 3 == 0) ? 1 : 2;
      issue(b, l);
      wait_done(5000, "rand_timeout");
      check("rand_queue_drained", exp_q.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
